// File: rtl/framebuffer_scaled_pkg.sv
// Shared types and helpers for the scaled double-buffered framebuffer.
package fb_pkg;

  // One displayed pixel, {R,G,B}, 8 bits per channel.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Extra bits on the signed window compare so that x - win_x cannot overflow.
  localparam int C_WIN_GUARD_W = 2;

  // Default colour shown outside the window and while the pipeline is empty.
  localparam logic [23:0] C_BG_RGB = 24'h0000F0;

  // Expand a w-bit pixel held in v[w-1:0] to 8 bits by MSB-aligned bit
  // replication: 1-bit 1 -> FF, 3-bit abc -> abcabcab, 8-bit unchanged.
  function automatic logic [7:0] expand_px(input logic [7:0] v, input int w);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[i] = v[w - 1 - ((7 - i) % w)];
    end
    return res;
  endfunction

endpackage

// File: rtl/framebuffer_scaled_if.sv
// Pixel write stream into the back bank: valid/ready handshake plus end-of-frame.
interface framebuffer_scaled_if #(
  parameter int P_DATA_W = 8
) ();
  logic                i_wr_valid;
  logic                o_wr_ready;
  logic [P_DATA_W-1:0] i_wr_data;
  logic                i_wr_last;

  modport master (output i_wr_valid, output i_wr_data, output i_wr_last, input o_wr_ready);
  modport slave  (input i_wr_valid, input i_wr_data, input i_wr_last, output o_wr_ready);
endinterface

// File: rtl/framebuffer_scaled_bram.sv
// Simple dual-port block RAM: one clock, one write port, one read port,
// read latency of 1 or 2 cycles.
module fb_bram_sdp #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_q;

  // Write port.
  // NOTE: the array has no reset branch so it maps onto block RAM; contents
  // survive i_rst and a freshly powered-up buffer holds whatever the RAM holds.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port.
  // NOTE: sequential state is always assigned with <= so every flop samples the
  // pre-edge values regardless of statement or block ordering.
  always_ff @(posedge i_clk) begin
    r_rd_q <= r_mem[i_rd_addr];
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] r_rd_q2;
      // Optional output register for the two-cycle configuration.
      always_ff @(posedge i_clk) begin
        r_rd_q2 <= r_rd_q;
      end
      assign o_rd_data = r_rd_q2;
    end else begin : g_lat1
      assign o_rd_data = r_rd_q;
    end
  endgenerate

endmodule

// File: rtl/framebuffer_scaled.sv
// Double-buffered framebuffer displayed as an integer-upscaled window on screen.
// Front bank is read for display, back bank is filled by the write stream and
// the banks swap on the first i_frame after a completed (i_wr_last) frame.
module framebuffer_scaled
  import fb_pkg::*;
#(
  parameter int          P_FB_WIDTH    = 160,
  parameter int          P_FB_HEIGHT   = 120,
  parameter int          P_DATA_W      = 8,
  parameter int          P_SCALE       = 2,
  parameter int          P_COUNT_W     = 16,
  parameter int          P_MEM_LATENCY = 1,
  parameter logic [23:0] P_BG_RGB      = C_BG_RGB
) (
  input  logic                        i_clk_pixel,
  input  logic                        i_rst,
  input  logic                        i_frame,
  input  logic signed [P_COUNT_W-1:0] i_x_pos,
  input  logic signed [P_COUNT_W-1:0] i_y_pos,
  input  logic signed [P_COUNT_W-1:0] i_win_x,
  input  logic signed [P_COUNT_W-1:0] i_win_y,
  framebuffer_scaled_if.slave         wr_if,
  output rgb_t                        o_data,
  output logic                        o_draw_valid,
  output logic                        o_buf_sel
);

  localparam int C_PIXELS = P_FB_WIDTH * P_FB_HEIGHT;
  localparam int C_DEPTH  = 2 * C_PIXELS;
  localparam int C_PIX_AW = $clog2(C_PIXELS);
  localparam int C_MEM_AW = $clog2(C_DEPTH);
  localparam int C_SHIFT  = $clog2(P_SCALE);
  localparam int C_COL_W  = ($clog2(P_FB_WIDTH) > 0) ? $clog2(P_FB_WIDTH) : 1;
  localparam int C_ROW_W  = ($clog2(P_FB_HEIGHT) > 0) ? $clog2(P_FB_HEIGHT) : 1;
  localparam int C_CMP_W  = P_COUNT_W + C_WIN_GUARD_W;

  localparam logic signed [C_CMP_W-1:0] C_SPAN_X     = C_CMP_W'(P_FB_WIDTH * P_SCALE);
  localparam logic signed [C_CMP_W-1:0] C_SPAN_Y     = C_CMP_W'(P_FB_HEIGHT * P_SCALE);
  localparam logic [C_PIX_AW-1:0]       C_LAST_PIX   = C_PIX_AW'(C_PIXELS - 1);
  localparam logic [C_PIX_AW-1:0]       C_WIDTH_A    = C_PIX_AW'(P_FB_WIDTH);
  localparam logic [C_MEM_AW-1:0]       C_BANK1_BASE = C_MEM_AW'(C_PIXELS);

  logic signed [C_CMP_W-1:0] w_dx, w_dy;
  logic                      w_in_win;
  logic [C_COL_W-1:0]        w_col;
  logic [C_ROW_W-1:0]        w_row;
  logic [C_PIX_AW-1:0]       w_rd_pix;
  logic [C_MEM_AW-1:0]       w_rd_addr, w_wr_addr;
  logic [P_DATA_W-1:0]       w_rd_data;
  logic                      w_wr_fire;
  logic [7:0]                w_px8, w_chan;
  logic                      w_unused_bits;

  logic [C_PIX_AW-1:0]       r_rd_pix;
  logic [P_MEM_LATENCY:0]    r_valid_pipe;
  logic [C_PIX_AW-1:0]       r_wr_pix;
  logic                      r_buf_sel;
  logic                      r_swap_pending;

  // Screen position relative to the window origin, sign-extended so that
  // negative and partly off-screen origins compare correctly.
  assign w_dx = $signed({{C_WIN_GUARD_W{i_x_pos[P_COUNT_W-1]}}, i_x_pos})
              - $signed({{C_WIN_GUARD_W{i_win_x[P_COUNT_W-1]}}, i_win_x});
  assign w_dy = $signed({{C_WIN_GUARD_W{i_y_pos[P_COUNT_W-1]}}, i_y_pos})
              - $signed({{C_WIN_GUARD_W{i_win_y[P_COUNT_W-1]}}, i_win_y});

  assign w_in_win = !w_dx[C_CMP_W-1] && (w_dx < C_SPAN_X)
                 && !w_dy[C_CMP_W-1] && (w_dy < C_SPAN_Y);

  // Dropping log2(scale) low bits turns screen offset into stored pixel index;
  // the result is only meaningful when w_in_win is set.
  assign w_col    = w_dx[C_SHIFT +: C_COL_W];
  assign w_row    = w_dy[C_SHIFT +: C_ROW_W];
  assign w_rd_pix = C_PIX_AW'(w_row) * C_WIDTH_A + C_PIX_AW'(w_col);
  assign w_unused_bits = ^{w_dx, w_dy};

  // Read-address stage and window-valid pipeline aligned with the RAM latency.
  always_ff @(posedge i_clk_pixel) begin
    r_rd_pix <= w_rd_pix;
    if (i_rst) r_valid_pipe <= '0;
    else       r_valid_pipe <= {r_valid_pipe[P_MEM_LATENCY-1:0], w_in_win};
  end

  // Bank select is the most significant digit of the RAM address
  // (bank * pixels + pixel). It is applied at the RAM port with the current
  // r_buf_sel, so reads and writes always land in opposite banks even on the
  // swap edge.
  assign w_rd_addr = r_buf_sel ? C_BANK1_BASE + C_MEM_AW'(r_rd_pix) : C_MEM_AW'(r_rd_pix);
  assign w_wr_addr = r_buf_sel ? C_MEM_AW'(r_wr_pix) : C_BANK1_BASE + C_MEM_AW'(r_wr_pix);

  assign wr_if.o_wr_ready = ~r_swap_pending;
  assign w_wr_fire        = wr_if.i_wr_valid & ~r_swap_pending;

  // Write address, end-of-frame latch and bank swap on the frame pulse.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      r_buf_sel      <= 1'b0;
      r_swap_pending <= 1'b0;
      r_wr_pix       <= '0;
    end else if (i_frame && r_swap_pending) begin
      r_buf_sel      <= ~r_buf_sel;
      r_swap_pending <= 1'b0;
      r_wr_pix       <= '0;
    end else if (w_wr_fire) begin
      r_wr_pix <= (r_wr_pix == C_LAST_PIX) ? '0 : r_wr_pix + 1'b1;
      if (wr_if.i_wr_last) r_swap_pending <= 1'b1;
    end
  end

  assign o_buf_sel = r_buf_sel;

  fb_bram_sdp #(
    .WIDTH  (P_DATA_W),
    .DEPTH  (C_DEPTH),
    .LATENCY(P_MEM_LATENCY)
  ) u_bram (
    .i_clk    (i_clk_pixel),
    .i_wr_en  (w_wr_fire),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(wr_if.i_wr_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  // Colour expansion and background substitution outside the window.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_px8                 = '0;
    w_px8[P_DATA_W-1:0]   = w_rd_data;
    w_chan                = expand_px(w_px8, P_DATA_W);
    o_draw_valid          = r_valid_pipe[P_MEM_LATENCY];
    o_data                = P_BG_RGB;
    if (r_valid_pipe[P_MEM_LATENCY]) o_data = '{r: w_chan, g: w_chan, b: w_chan};
  end

endmodule

// File: tb/tb_framebuffer_scaled.sv
// Directed bench: default-parameter framebuffer plus a small 1-bit, scale-1,
// two-cycle-RAM instance; expected values are hand-computed per scenario.
module tb_framebuffer_scaled;
  import fb_pkg::*;

  localparam logic [23:0] BG = 24'h0000F0;

  typedef struct {
    int          wx;
    int          wy;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic frame_a, frame_b;
  logic signed [15:0] x_a, y_a, wx_a, wy_a, x_b, y_b, wx_b, wy_b;
  rgb_t data_a, data_b;
  logic dv_a, dv_b, sel_a, sel_b;
  int errors = 0;
  int checks = 0;

  framebuffer_scaled_if #(.P_DATA_W(8)) wr_a ();
  framebuffer_scaled_if #(.P_DATA_W(1)) wr_b ();

  always #5 clk = ~clk;

  framebuffer_scaled u_dut_a (
    .i_clk_pixel (clk),
    .i_rst       (rst),
    .i_frame     (frame_a),
    .i_x_pos     (x_a),
    .i_y_pos     (y_a),
    .i_win_x     (wx_a),
    .i_win_y     (wy_a),
    .wr_if       (wr_a),
    .o_data      (data_a),
    .o_draw_valid(dv_a),
    .o_buf_sel   (sel_a)
  );

  framebuffer_scaled #(
    .P_FB_WIDTH   (4),
    .P_FB_HEIGHT  (2),
    .P_DATA_W     (1),
    .P_SCALE      (1),
    .P_MEM_LATENCY(2)
  ) u_dut_b (
    .i_clk_pixel (clk),
    .i_rst       (rst),
    .i_frame     (frame_b),
    .i_x_pos     (x_b),
    .i_y_pos     (y_b),
    .i_win_x     (wx_b),
    .i_win_y     (wy_b),
    .wr_if       (wr_b),
    .o_data      (data_b),
    .o_draw_valid(dv_b),
    .o_buf_sel   (sel_b)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic write_a(input logic [7:0] d, input logic last);
    @(negedge clk);
    wr_a.i_wr_valid = 1'b1;
    wr_a.i_wr_data  = d;
    wr_a.i_wr_last  = last;
  endtask

  task automatic idle_a();
    @(negedge clk);
    wr_a.i_wr_valid = 1'b0;
    wr_a.i_wr_last  = 1'b0;
  endtask

  task automatic pulse_frame_a();
    @(negedge clk);
    frame_a = 1'b1;
    @(negedge clk);
    frame_a = 1'b0;
  endtask

  // Present a position and wait out the two-cycle latency.
  task automatic present_a(input vec_t v);
    @(negedge clk);
    wx_a = 16'(v.wx);
    wy_a = 16'(v.wy);
    x_a  = 16'(v.x);
    y_a  = 16'(v.y);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Small instance has a two-cycle RAM, so three cycles end to end.
  task automatic present_b(input vec_t v);
    @(negedge clk);
    wx_b = 16'(v.wx);
    wy_b = 16'(v.wy);
    x_b  = 16'(v.x);
    y_b  = 16'(v.y);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (sel_a !== 1'b0) begin errors++; $display("FAIL reset_sel_a: got %b want 0", sel_a); end
    if (wr_a.o_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b want 1", wr_a.o_wr_ready); end
    if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_dv_a: got %b want 0", dv_a); end
    if (data_a !== BG) begin errors++; $display("FAIL reset_data_a: got %h want %h", data_a, BG); end
    if (sel_b !== 1'b0) begin errors++; $display("FAIL reset_sel_b: got %b want 0", sel_b); end
    if (wr_b.o_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b want 1", wr_b.o_wr_ready); end
    if (dv_b !== 1'b0) begin errors++; $display("FAIL reset_dv_b: got %b want 0", dv_b); end
    rst = 1'b0;
  endtask

  // Fill bank 1 with a ramp (pixel i = i mod 256), then swap it to the front.
  task automatic test_write_swap();
    for (int i = 0; i < 19200; i++) write_a(8'(i), (i == 19199));
    idle_a();
    checks += 2;
    if (wr_a.o_wr_ready !== 1'b0) begin errors++; $display("FAIL swap_ready_low: got %b want 0", wr_a.o_wr_ready); end
    if (sel_a !== 1'b0) begin errors++; $display("FAIL swap_sel_before: got %b want 0", sel_a); end
    // Offered while not ready: must be dropped (would otherwise clobber address 0).
    write_a(8'hEE, 1'b1);
    write_a(8'hEE, 1'b1);
    idle_a();
    pulse_frame_a();
    checks += 2;
    if (sel_a !== 1'b1) begin errors++; $display("FAIL swap_sel_after: got %b want 1", sel_a); end
    if (wr_a.o_wr_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_back: got %b want 1", wr_a.o_wr_ready); end
  endtask

  task automatic test_window();
    vec_t t [13];
    t = '{
      '{240, 180, 240, 180, 24'h000000, 1'b1},
      '{240, 180, 241, 181, 24'h000000, 1'b1},
      '{240, 180, 242, 180, 24'h010101, 1'b1},
      '{240, 180, 559, 419, 24'hFFFFFF, 1'b1},
      '{240, 180, 239, 180, BG,         1'b0},
      '{240, 180, 560, 180, BG,         1'b0},
      '{240, 180, 240, 179, BG,         1'b0},
      '{240, 180, 240, 420, BG,         1'b0},
      '{-2,  -2,  0,   0,   24'hA1A1A1, 1'b1},
      '{-2,  -2,  -3,  0,   BG,         1'b0},
      '{-2,  -2,  317, 0,   24'h3F3F3F, 1'b1},
      '{-2,  -2,  318, 0,   BG,         1'b0},
      '{-2,  -2,  -2,  237, 24'h606060, 1'b1}
    };
    for (int k = 0; k < 13; k++) begin
      present_a(t[k]);
      checks++;
      if (data_a !== t[k].rgb || dv_a !== t[k].v)
        begin errors++; $display("FAIL window[%0d] (%0d,%0d): got %h/%b want %h/%b", k, t[k].x, t[k].y, data_a, dv_a, t[k].rgb, t[k].v); end
    end
  endtask

  // A new position every cycle; each result is due two cycles later.
  task automatic test_back_to_back();
    vec_t t [6];
    t = '{
      '{240, 180, 240, 180, 24'h000000, 1'b1},
      '{240, 180, 239, 180, BG,         1'b0},
      '{240, 180, 242, 180, 24'h010101, 1'b1},
      '{240, 180, 559, 419, 24'hFFFFFF, 1'b1},
      '{240, 180, 560, 180, BG,         1'b0},
      '{240, 180, 245, 181, 24'h020202, 1'b1}
    };
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (data_a !== t[k-2].rgb || dv_a !== t[k-2].v)
          begin errors++; $display("FAIL b2b[%0d]: got %h/%b want %h/%b", k - 2, data_a, dv_a, t[k-2].rgb, t[k-2].v); end
      end
      if (k < 6) begin
        wx_a = 16'(t[k].wx);
        wy_a = 16'(t[k].wy);
        x_a  = 16'(t[k].x);
        y_a  = 16'(t[k].y);
      end
    end
  endtask

  // 19201 writes without last into bank 0: the extra one wraps to address 0.
  task automatic test_wrap();
    vec_t t [4];
    for (int i = 0; i < 19200; i++) write_a(8'(i), 1'b0);
    write_a(8'h5A, 1'b0);
    idle_a();
    checks++;
    if (wr_a.o_wr_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b want 1", wr_a.o_wr_ready); end
    pulse_frame_a();
    checks++;
    if (sel_a !== 1'b1) begin errors++; $display("FAIL wrap_no_swap: got %b want 1", sel_a); end
    // Address was left at 1, so this one lands there; then bring bank 0 forward.
    write_a(8'hA5, 1'b1);
    idle_a();
    checks++;
    if (wr_a.o_wr_ready !== 1'b0) begin errors++; $display("FAIL wrap_last_ready: got %b want 0", wr_a.o_wr_ready); end
    pulse_frame_a();
    checks++;
    if (sel_a !== 1'b0) begin errors++; $display("FAIL wrap_swap_sel: got %b want 0", sel_a); end
    t = '{
      '{240, 180, 240, 180, 24'h5A5A5A, 1'b1},
      '{240, 180, 242, 180, 24'hA5A5A5, 1'b1},
      '{240, 180, 244, 180, 24'h020202, 1'b1},
      '{240, 180, 241, 183, 24'hA0A0A0, 1'b1}
    };
    for (int k = 0; k < 4; k++) begin
      present_a(t[k]);
      checks++;
      if (data_a !== t[k].rgb || dv_a !== t[k].v)
        begin errors++; $display("FAIL wrap_read[%0d]: got %h/%b want %h/%b", k, data_a, dv_a, t[k].rgb, t[k].v); end
    end
  endtask

  // Last pixel accepted on the frame edge: swap waits for the next frame.
  task automatic test_frame_coincide();
    vec_t t [2];
    @(negedge clk);
    wr_a.i_wr_valid = 1'b1;
    wr_a.i_wr_data  = 8'h77;
    wr_a.i_wr_last  = 1'b1;
    frame_a         = 1'b1;
    @(negedge clk);
    wr_a.i_wr_valid = 1'b0;
    wr_a.i_wr_last  = 1'b0;
    frame_a         = 1'b0;
    checks += 2;
    if (sel_a !== 1'b0) begin errors++; $display("FAIL coincide_sel: got %b want 0", sel_a); end
    if (wr_a.o_wr_ready !== 1'b0) begin errors++; $display("FAIL coincide_ready: got %b want 0", wr_a.o_wr_ready); end
    pulse_frame_a();
    checks += 2;
    if (sel_a !== 1'b1) begin errors++; $display("FAIL coincide_sel_next: got %b want 1", sel_a); end
    if (wr_a.o_wr_ready !== 1'b1) begin errors++; $display("FAIL coincide_ready_next: got %b want 1", wr_a.o_wr_ready); end
    t = '{
      '{240, 180, 240, 180, 24'h777777, 1'b1},
      '{240, 180, 242, 180, 24'h010101, 1'b1}
    };
    for (int k = 0; k < 2; k++) begin
      present_a(t[k]);
      checks++;
      if (data_a !== t[k].rgb || dv_a !== t[k].v)
        begin errors++; $display("FAIL coincide_read[%0d]: got %h/%b want %h/%b", k, data_a, dv_a, t[k].rgb, t[k].v); end
    end
  endtask

  task automatic test_reset_mid_write();
    vec_t t [3];
    write_a(8'h11, 1'b0);
    write_a(8'h22, 1'b0);
    write_a(8'h33, 1'b0);
    write_a(8'h44, 1'b1);
    @(negedge clk);
    wr_a.i_wr_valid = 1'b0;
    wr_a.i_wr_last  = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (sel_a !== 1'b0) begin errors++; $display("FAIL rstmid_sel: got %b want 0", sel_a); end
    if (wr_a.o_wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", wr_a.o_wr_ready); end
    if (dv_a !== 1'b0) begin errors++; $display("FAIL rstmid_dv: got %b want 0", dv_a); end
    if (data_a !== BG) begin errors++; $display("FAIL rstmid_data: got %h want %h", data_a, BG); end
    rst = 1'b0;
    // Back bank is now bank 1 and the first write must go to address 0.
    write_a(8'h99, 1'b1);
    idle_a();
    pulse_frame_a();
    checks++;
    if (sel_a !== 1'b1) begin errors++; $display("FAIL rstmid_swap: got %b want 1", sel_a); end
    t = '{
      '{240, 180, 240, 180, 24'h999999, 1'b1},
      '{240, 180, 242, 180, 24'h010101, 1'b1},
      '{240, 180, 246, 180, 24'h030303, 1'b1}
    };
    for (int k = 0; k < 3; k++) begin
      present_a(t[k]);
      checks++;
      if (data_a !== t[k].rgb || dv_a !== t[k].v)
        begin errors++; $display("FAIL rstmid_read[%0d]: got %h/%b want %h/%b", k, data_a, dv_a, t[k].rgb, t[k].v); end
    end
  endtask

  // 4x2 image of 1-bit pixels, scale 1, three-cycle read path.
  task automatic test_data_w1();
    vec_t t [7];
    logic [7:0] pat;
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_b.i_wr_valid = 1'b1;
      wr_b.i_wr_data  = pat[i];
      wr_b.i_wr_last  = (i == 7);
    end
    @(negedge clk);
    wr_b.i_wr_valid = 1'b0;
    wr_b.i_wr_last  = 1'b0;
    frame_b         = 1'b1;
    @(negedge clk);
    frame_b = 1'b0;
    checks++;
    if (sel_b !== 1'b1) begin errors++; $display("FAIL w1_swap: got %b want 1", sel_b); end
    t = '{
      '{0, 0, 0,  0, 24'hFFFFFF, 1'b1},
      '{0, 0, 1,  0, 24'h000000, 1'b1},
      '{0, 0, 3,  0, 24'hFFFFFF, 1'b1},
      '{0, 0, 3,  1, 24'hFFFFFF, 1'b1},
      '{0, 0, 0,  1, 24'h000000, 1'b1},
      '{0, 0, 4,  0, BG,         1'b0},
      '{0, 0, -1, 0, BG,         1'b0}
    };
    for (int k = 0; k < 7; k++) begin
      present_b(t[k]);
      checks++;
      if (data_b !== t[k].rgb || dv_b !== t[k].v)
        begin errors++; $display("FAIL w1_read[%0d]: got %h/%b want %h/%b", k, data_b, dv_b, t[k].rgb, t[k].v); end
    end
  endtask

  initial begin
    rst             = 1'b1;
    frame_a         = 1'b0;
    frame_b         = 1'b0;
    wx_a            = 16'sd240;
    wy_a            = 16'sd180;
    x_a             = 16'sd240;
    y_a             = 16'sd180;
    wx_b            = '0;
    wy_b            = '0;
    x_b             = '0;
    y_b             = '0;
    wr_a.i_wr_valid = 1'b0;
    wr_a.i_wr_data  = '0;
    wr_a.i_wr_last  = 1'b0;
    wr_b.i_wr_valid = 1'b0;
    wr_b.i_wr_data  = '0;
    wr_b.i_wr_last  = 1'b0;
    test_reset();
    test_write_swap();
    test_window();
    test_back_to_back();
    test_wrap();
    test_frame_coincide();
    test_reset_mid_write();
    test_data_w1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/framebuffer_scaled.md
FRAMEBUFFER_SCALED -- requirements
Module: framebuffer_scaled

Interface
REQ-001 SHALL have parameter P_FB_WIDTH, default 160, stored image width in pixels.
REQ-002 SHALL have parameter P_FB_HEIGHT, default 120, stored image height in pixels.
REQ-003 SHALL have parameter P_DATA_W, default 8, stored pixel width in bits; legal range 1..8.
REQ-004 SHALL have parameter P_SCALE, default 2, integer upscale factor; legal values 1, 2, 4.
REQ-005 SHALL have parameter P_COUNT_W, default 16, width of the signed screen coordinates.
REQ-006 SHALL have parameter P_MEM_LATENCY, default 1, BRAM read latency in cycles (1 or 2).
REQ-007 SHALL have parameter P_BG_RGB, default 24'h0000F0, background colour as {R,G,B}.
REQ-008 SHALL have ports: i_clk_pixel in 1 pixel clock; i_rst in 1 reset, synchronous, active-high.
REQ-009 SHALL have ports: i_frame in 1 start-of-frame pulse; i_x_pos, i_y_pos in P_COUNT_W signed screen position.
REQ-010 SHALL have ports: i_win_x, i_win_y in P_COUNT_W signed window origin on screen, sampled every cycle.
REQ-011 SHALL have ports: i_wr_valid in 1, o_wr_ready out 1, i_wr_data in P_DATA_W, i_wr_last in 1 (last pixel of the written frame).
REQ-012 SHALL have ports: o_data out 3x8 {R,G,B}; o_draw_valid out 1, pixel inside window; o_buf_sel out 1, bank currently displayed.

Function
REQ-013 SHALL store two banks of P_FB_WIDTH*P_FB_HEIGHT pixels: the front bank is displayed and the back bank is written.
REQ-014 Window region SHALL be win_x <= x < win_x+P_FB_WIDTH*P_SCALE and win_y <= y < win_y+P_FB_HEIGHT*P_SCALE, using signed compares, so partially off-screen or negative origins are legal.
REQ-015 Read address SHALL be ((y-win_y)>>log2(P_SCALE))*P_FB_WIDTH + ((x-win_x)>>log2(P_SCALE)), computed in the front bank.
REQ-016 Latency SHALL be fixed at P_MEM_LATENCY+1 cycles: position presented at cycle t appears on o_data/o_draw_valid at t+P_MEM_LATENCY+1. The window-valid flag SHALL be pipelined alongside the read.
REQ-017 Inside the window, each o_data channel SHALL equal the stored pixel expanded to 8 bits by MSB-aligned bit replication (1-bit: 00/FF; 8-bit: unchanged).
REQ-018 Outside the window, o_data SHALL equal P_BG_RGB and o_draw_valid SHALL be 0.
REQ-019 o_wr_ready SHALL equal NOT swap_pending.
REQ-020 A write is accepted when i_wr_valid AND o_wr_ready. Each accepted write stores i_wr_data at the back-bank write address, then increments that address.
REQ-021 The write address SHALL wrap from P_FB_WIDTH*P_FB_HEIGHT-1 to 0 when no i_wr_last is seen.
REQ-022 An accepted write with i_wr_last SHALL set swap_pending, whatever the current address.
REQ-023 On i_frame with swap_pending=1: o_buf_sel toggles, swap_pending clears and the write address resets to 0, all in the same edge.
REQ-024 On i_frame with swap_pending=0: no swap occurs and the write address is unchanged.
REQ-025 When i_frame coincides with an accepted i_wr_last, swap_pending SHALL set and the swap SHALL occur at the next i_frame.
REQ-026 Reads and writes SHALL never target the same bank in the same cycle.

Reset
REQ-027 On i_rst: o_buf_sel=0, swap_pending=0, write address=0 and all pipeline valid flags=0. o_wr_ready SHALL read 1 after reset.
REQ-028 While valid flags are 0, o_data SHALL be P_BG_RGB and o_draw_valid 0.
REQ-029 BRAM contents SHALL NOT be cleared by reset. A reset mid-write abandons the partial frame.

Structure
REQ-030 Package fb_pkg SHALL hold the rgb_t typedef (3x8), the window-compare helper width constants and the default background constant.
REQ-031 Storage SHALL be the sub-module fb_bram_sdp: one clock, one write port and one read port, with parameters WIDTH, DEPTH and LATENCY. It SHALL be instantiated once at depth 2*P_FB_WIDTH*P_FB_HEIGHT, with the bank select as the address MSB.

Verification
REQ-032 Default parameters, window (240,180), bank 0 preloaded with a ramp: position (240,180) -> o_data={00,00,00} and o_draw_valid=1 two cycles later. Position (242,180) reads address 1; (559,419) reads address 19199.
REQ-033 Position (239,180) and position (560,180) -> o_data=0000F0 and o_draw_valid=0.
REQ-034 Write 19200 pixels with i_wr_last on the last one -> o_wr_ready=0 next cycle; at the next i_frame o_buf_sel 0->1 and o_wr_ready returns to 1.
REQ-035 Write 19201 pixels with no last -> the 19201st lands at address 0; o_buf_sel stays 0 through i_frame.
REQ-036 i_frame coincides with an accepted i_wr_last -> no toggle that frame; toggle at the following i_frame.
REQ-037 P_DATA_W=1, value 1 -> o_data={FF,FF,FF}. i_rst asserted mid-write -> o_buf_sel=0, o_wr_ready=1, and the next write goes to address 0.
